mem_access_unit: RTL and testbench

- Initiator on the pipeline's data-memory port; drives the word-addressed data-memory interface.
  - Memory side: `mem_addr`, `mem_wdata`, `mem_rdata`, `mem_read`, `mem_write`.
  - The memory returns read data combinationally and commits writes on the clock edge.
- Accepts one load or store at a time from the MEM stage through a valid/ready handshake.
- Performs byte/halfword extraction and sign extension on loads, and read-modify-write for sub-word stores.
- Returns a single-cycle response carrying the load data or an alignment error.

---
 rtl/mem_access_unit.sv | 218 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: data-memory initiator for the MEM stage.
// Sub-word loads/stores (LB/LH/LBU/LHU/SB/SH) are built only when MAU_SUBWORD_EN is defined.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_read,
  output logic        mem_write
);

  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP
  } state_t;

  state_t      r_state;
  logic        r_ready;
  logic        r_rvalid;
  logic        r_err;
  logic        r_mrd;
  logic        r_mwr;
  logic [31:0] r_rdata;
  logic [31:0] r_maddr;
  logic [31:0] r_mwdata;

  logic        w_accept;
  logic        w_misal;
  logic        w_bad;
  logic        w_is_load;
  logic [31:0] w_ldata;

  assign w_accept  = req_valid && r_ready;
  assign w_is_load = !req_op[2] || (req_op == OP_LHU);

  always_comb begin
    w_misal = 1'b0;
    if ((req_op == OP_LH || req_op == OP_LHU || req_op == OP_SH) && req_addr[0])
      w_misal = 1'b1;
    if ((req_op == OP_LW || req_op == OP_SW) && (req_addr[1:0] != 2'b00))
      w_misal = 1'b1;
  end

`ifdef MAU_SUBWORD_EN
  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_SB  = 3'd5;

  logic [2:0]  r_op;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_merge;

  assign w_bad = w_misal;

  always_comb begin
    w_byte = mem_rdata[7:0];
    unique case (r_lane)
      2'd0: w_byte = mem_rdata[7:0];
      2'd1: w_byte = mem_rdata[15:8];
      2'd2: w_byte = mem_rdata[23:16];
      2'd3: w_byte = mem_rdata[31:24];
      default: w_byte = mem_rdata[7:0];
    endcase
    w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  always_comb begin
    w_ldata = mem_rdata;
    unique case (r_op)
      OP_LB:   w_ldata = {{24{w_byte[7]}}, w_byte};
      OP_LH:   w_ldata = {{16{w_half[15]}}, w_half};
      OP_LBU:  w_ldata = {24'd0, w_byte};
      OP_LHU:  w_ldata = {16'd0, w_half};
      default: w_ldata = mem_rdata;
    endcase
  end

  // Only SB/SH reach RMW_RD, so r_op is one of those two here.
  always_comb begin
    w_merge = mem_rdata;
    if (r_op == OP_SB) begin
      unique case (r_lane)
        2'd0: w_merge[7:0]   = r_wdata[7:0];
        2'd1: w_merge[15:8]  = r_wdata[7:0];
        2'd2: w_merge[23:16] = r_wdata[7:0];
        2'd3: w_merge[31:24] = r_wdata[7:0];
        default: w_merge = mem_rdata;
      endcase
    end else if (r_lane[1]) begin
      w_merge[31:16] = r_wdata;
    end else begin
      w_merge[15:0] = r_wdata;
    end
  end
`else
  assign w_bad   = w_misal || !(req_op == OP_LW || req_op == OP_SW);
  assign w_ldata = mem_rdata;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_ready  <= 1'b1;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_mrd    <= 1'b0;
      r_mwr    <= 1'b0;
      r_rdata  <= 32'd0;
      r_maddr  <= 32'd0;
      r_mwdata <= 32'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
`ifdef MAU_SUBWORD_EN
            r_op    <= req_op;
            r_lane  <= req_addr[1:0];
            r_wdata <= req_wdata[15:0];
`endif
            r_maddr <= {req_addr[31:2], 2'b00};
            r_ready <= 1'b0;
            if (w_bad) begin
              r_state  <= S_RESP;
              r_err    <= 1'b1;
              r_rdata  <= 32'd0;
              r_rvalid <= 1'b1;
            end else if (w_is_load) begin
              r_state <= S_LOAD;
              r_mrd   <= 1'b1;
`ifdef MAU_SUBWORD_EN
            end else if (req_op != OP_SW) begin
              r_state <= S_RMW_RD;
              r_mrd   <= 1'b1;
`endif
            end else begin
              r_state  <= S_STORE;
              r_mwr    <= 1'b1;
              r_mwdata <= req_wdata;
            end
          end
        end
        S_LOAD: begin
          r_state  <= S_RESP;
          r_mrd    <= 1'b0;
          r_rdata  <= w_ldata;
          r_err    <= 1'b0;
          r_rvalid <= 1'b1;
        end
`ifdef MAU_SUBWORD_EN
        S_RMW_RD: begin
          r_state  <= S_RMW_WR;
          r_mrd    <= 1'b0;
          r_mwr    <= 1'b1;
          r_mwdata <= w_merge;
        end
        S_RMW_WR: begin
          r_state  <= S_RESP;
          r_mwr    <= 1'b0;
          r_rdata  <= 32'd0;
          r_err    <= 1'b0;
          r_rvalid <= 1'b1;
        end
`endif
        S_STORE: begin
          r_state  <= S_RESP;
          r_mwr    <= 1'b0;
          r_rdata  <= 32'd0;
          r_err    <= 1'b0;
          r_rvalid <= 1'b1;
        end
        S_RESP: begin
          r_state  <= S_IDLE;
          r_rvalid <= 1'b0;
          r_ready  <= 1'b1;
        end
        default: begin
          r_state  <= S_IDLE;
          r_rvalid <= 1'b0;
          r_mrd    <= 1'b0;
          r_mwr    <= 1'b0;
          r_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = r_ready;
  assign resp_valid = r_rvalid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign mem_addr   = r_maddr;
  assign mem_wdata  = r_mwdata;
  assign mem_read   = r_mrd;
  assign mem_write  = r_mwr;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench with a small word memory model.
// Sub-word vectors run only when MAU_SUBWORD_EN is defined.
module tb_mem_access_unit;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd3;
  localparam logic [2:0] SB  = 3'd5;
  localparam logic [2:0] SH  = 3'd6;
  localparam logic [2:0] SW  = 3'd7;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_read;
  logic        mem_write;

  logic [31:0] mem [0:63];
  logic        pre_we;
  logic [5:0]  pre_idx;
  logic [31:0] pre_data;

  int n_chk;
  int n_err;
  int n_both;

  mem_access_unit dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
  end

  always @(negedge clk) begin
    if (mem_read && mem_write) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Issue one request; mask bit i marks a strobe seen in cycle A+i.
  task automatic xact(input string tag, input logic [2:0] op,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input int e_lat, input logic e_err,
                      input logic [31:0] e_rd, input logic [7:0] e_rm,
                      input logic [7:0] e_wm);
    int lat;
    logic err;
    logic [31:0] rd;
    logic [7:0] rm;
    logic [7:0] wm;
    lat = 0; err = 1'b0; rd = 32'd0; rm = 8'd0; wm = 8'd0;
    @(negedge clk);
    check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 1; i <= 7 && lat == 0; i++) begin
      @(negedge clk);
      if (mem_read)  rm[i] = 1'b1;
      if (mem_write) wm[i] = 1'b1;
      if (resp_valid) begin
        lat = i;
        err = resp_err;
        rd  = resp_rdata;
      end
    end
    check({tag, ".lat"}, lat, e_lat);
    check({tag, ".err"}, {31'd0, err}, {31'd0, e_err});
    check({tag, ".rdata"}, rd, e_rd);
    check({tag, ".rdmask"}, {24'd0, rm}, {24'd0, e_rm});
    check({tag, ".wrmask"}, {24'd0, wm}, {24'd0, e_wm});
  endtask

  initial begin
    n_chk = 0; n_err = 0; n_both = 0;
    reset = 1'b0;
    req_valid = 1'b0;
    req_op = 3'd0;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    pre_we = 1'b1;
    pre_idx = 6'd4;
    pre_data = 32'h8899AABB;
    @(posedge clk);
    #1 pre_we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst.ready", {31'd0, req_ready}, 32'd1);
    check("rst.rvalid", {31'd0, resp_valid}, 32'd0);
    check("rst.err", {31'd0, resp_err}, 32'd0);
    check("rst.rdata", resp_rdata, 32'd0);
    check("rst.mrd", {31'd0, mem_read}, 32'd0);
    check("rst.mwr", {31'd0, mem_write}, 32'd0);
    check("rst.maddr", mem_addr, 32'd0);
    check("rst.mwdata", mem_wdata, 32'd0);
    reset = 1'b1;

    xact("lw10", LW, 32'h10, 32'd0, 2, 1'b0, 32'h8899AABB, 8'h02, 8'h00);
    xact("lw12", LW, 32'h12, 32'd0, 1, 1'b1, 32'd0, 8'h00, 8'h00);
    xact("sh13", SH, 32'h13, 32'h1111, 1, 1'b1, 32'd0, 8'h00, 8'h00);
    xact("sw21", SW, 32'h21, 32'h1, 1, 1'b1, 32'd0, 8'h00, 8'h00);
`ifdef MAU_SUBWORD_EN
    xact("lb11", LB, 32'h11, 32'd0, 2, 1'b0, 32'hFFFFFFAA, 8'h02, 8'h00);
    xact("lbu11", LBU, 32'h11, 32'd0, 2, 1'b0, 32'h000000AA, 8'h02, 8'h00);
    xact("lh12", LH, 32'h12, 32'd0, 2, 1'b0, 32'hFFFF8899, 8'h02, 8'h00);
    xact("sb12", SB, 32'h12, 32'h55, 3, 1'b0, 32'd0, 8'h02, 8'h04);
    check("sb12.mem", mem[4], 32'h8855AABB);
    xact("lw10b", LW, 32'h10, 32'd0, 2, 1'b0, 32'h8855AABB, 8'h02, 8'h00);
    // reset lands on the RMW_RD cycle of SH 0x10
    @(negedge clk);
    req_valid = 1'b1; req_op = SH; req_addr = 32'h10; req_wdata = 32'h1234;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rstrmw.mrd", {31'd0, mem_read}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("rstrmw.ready", {31'd0, req_ready}, 32'd1);
    check("rstrmw.rvalid", {31'd0, resp_valid}, 32'd0);
    check("rstrmw.mwr", {31'd0, mem_write}, 32'd0);
    @(negedge clk);
    check("rstrmw.rvalid2", {31'd0, resp_valid}, 32'd0);
    check("rstrmw.mem", mem[4], 32'h8855AABB);
`else
    xact("lb10", LB, 32'h10, 32'd0, 1, 1'b1, 32'd0, 8'h00, 8'h00);
    xact("sb12", SB, 32'h12, 32'h55, 1, 1'b1, 32'd0, 8'h00, 8'h00);
    check("sb12.mem", mem[4], 32'h8899AABB);
`endif
    xact("sw20", SW, 32'h20, 32'hDEADBEEF, 2, 1'b0, 32'd0, 8'h00, 8'h02);
    xact("lw20", LW, 32'h20, 32'd0, 2, 1'b0, 32'hDEADBEEF, 8'h02, 8'h00);

    // reset on the STORE cycle: that write still commits
    @(negedge clk);
    req_valid = 1'b1; req_op = SW; req_addr = 32'h30; req_wdata = 32'h12345678;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rstst.mwr", {31'd0, mem_write}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("rstst.ready", {31'd0, req_ready}, 32'd1);
    check("rstst.rvalid", {31'd0, resp_valid}, 32'd0);
    check("rstst.maddr", mem_addr, 32'd0);
    xact("lw30", LW, 32'h30, 32'd0, 2, 1'b0, 32'h12345678, 8'h02, 8'h00);

    check("rd_and_wr", n_both, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
